// File: rtl/opb_spi_arbiter.sv
// opb_spi_arbiter: two-requester round-robin master arbiter in front of the SPI OPB slave port.
// Drives one OPB transfer at a time, returns read data or a timeout error, then enforces a
// recovery gap (HOLD) so a slave that keeps xferack asserted cannot complete the next transfer.
module opb_spi_arbiter #(
  parameter int unsigned TIMEOUT = 16,
  parameter int unsigned HOLDOFF = 3
) (
  input  logic        opb_clk,
  input  logic        reset_n,
  input  logic [1:0]  req,
  input  logic [1:0]  req_rnw,
  input  logic [31:0] req_addr,
  input  logic [63:0] req_wdata,
  output logic [1:0]  gnt,
  output logic [1:0]  done,
  output logic [1:0]  err,
  output logic [31:0] rdata,
  output logic        busy,
  output logic        opb_select,
  output logic        opb_rnw,
  output logic [15:0] opb_abus,
  output logic [31:0] opb_dbus,
  input  logic [31:0] sl_dbus,
  input  logic        sl_xferack
);

  localparam int unsigned TW = $clog2(TIMEOUT) + 1;
  localparam int unsigned HW = $clog2(HOLDOFF + 1) + 1;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] XFER = 2'd1;
  localparam logic [1:0] HOLD = 2'd2;

  localparam logic [TW-1:0] TimerLast = TW'(TIMEOUT - 1);
  // hold_q counts HOLD edges already spent; the HOLDOFF-th edge may exit.
  localparam logic [HW-1:0] HoldLast  = HW'(HOLDOFF - 1);

  logic [1:0]    state_q, state_d;
  logic [TW-1:0] timer_q, timer_d;
  logic [HW-1:0] hold_q, hold_d;
  logic          last_q, last_d;
  logic [1:0]    gnt_q, gnt_d;
  logic [1:0]    done_q, done_d;
  logic [1:0]    err_q, err_d;
  logic [31:0]   rdata_q, rdata_d;
  logic          sel_q, sel_d;
  logic          rnw_q, rnw_d;
  logic [15:0]   abus_q, abus_d;
  logic [31:0]   dbus_q, dbus_d;

  // m1 wins when it requests alone, or when both request and m0 was served last.
  logic pick_m1;
  assign pick_m1 = req[1] & (~req[0] | ~last_q);

  // Next-state logic for the IDLE -> XFER -> HOLD -> IDLE sequence.
  always_comb begin
    state_d = state_q;
    timer_d = timer_q;
    hold_d  = hold_q;
    last_d  = last_q;
    gnt_d   = gnt_q;
    done_d  = 2'b00;
    err_d   = 2'b00;
    rdata_d = rdata_q;
    sel_d   = sel_q;
    rnw_d   = rnw_q;
    abus_d  = abus_q;
    dbus_d  = dbus_q;
    case (state_q)
      IDLE: begin
        if (|req) begin
          state_d = XFER;
          gnt_d   = pick_m1 ? 2'b10 : 2'b01;
          sel_d   = 1'b1;
          rnw_d   = req_rnw[pick_m1];
          abus_d  = pick_m1 ? req_addr[31:16] : req_addr[15:0];
          dbus_d  = pick_m1 ? req_wdata[63:32] : req_wdata[31:0];
          timer_d = '0;
        end
      end
      XFER: begin
        if (sl_xferack) begin
          if (rnw_q) rdata_d = sl_dbus;
          done_d  = gnt_q;
          sel_d   = 1'b0;
          hold_d  = '0;
          state_d = HOLD;
        end else if (timer_q == TimerLast) begin
          done_d  = gnt_q;
          err_d   = gnt_q;
          sel_d   = 1'b0;
          hold_d  = '0;
          state_d = HOLD;
        end else begin
          timer_d = timer_q + TW'(1);
        end
      end
      HOLD: begin
        if ((hold_q >= HoldLast) && !sl_xferack) begin
          gnt_d   = 2'b00;
          last_d  = gnt_q[1];
          rnw_d   = 1'b0;
          abus_d  = '0;
          dbus_d  = '0;
          state_d = IDLE;
        end else if (hold_q < HoldLast) begin
          hold_d = hold_q + HW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State registers; reset clears everything and biases the first grant to m0.
  always_ff @(posedge opb_clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      timer_q <= '0;
      hold_q  <= '0;
      last_q  <= 1'b1;
      gnt_q   <= 2'b00;
      done_q  <= 2'b00;
      err_q   <= 2'b00;
      rdata_q <= '0;
      sel_q   <= 1'b0;
      rnw_q   <= 1'b0;
      abus_q  <= '0;
      dbus_q  <= '0;
    end else begin
      state_q <= state_d;
      timer_q <= timer_d;
      hold_q  <= hold_d;
      last_q  <= last_d;
      gnt_q   <= gnt_d;
      done_q  <= done_d;
      err_q   <= err_d;
      rdata_q <= rdata_d;
      sel_q   <= sel_d;
      rnw_q   <= rnw_d;
      abus_q  <= abus_d;
      dbus_q  <= dbus_d;
    end
  end

  assign gnt        = gnt_q;
  assign done       = done_q;
  assign err        = err_q;
  assign rdata      = rdata_q;
  assign busy       = (state_q != IDLE);
  assign opb_select = sel_q;
  assign opb_rnw    = rnw_q;
  assign opb_abus   = abus_q;
  assign opb_dbus   = dbus_q;

endmodule

// File: tb/tb_opb_spi_arbiter.sv
// Testbench for opb_spi_arbiter: a responsive slave model plus a transaction monitor feed
// scenario tasks that compare against a transaction-level arbitration/timing model.
module tb_opb_spi_arbiter;

  localparam int TIMEOUT = 16;
  localparam int HOLDOFF = 3;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [1:0]  req;
  logic [1:0]  req_rnw;
  logic [31:0] req_addr;
  logic [63:0] req_wdata;
  logic [1:0]  gnt, done, err;
  logic [31:0] rdata;
  logic        busy, opb_select, opb_rnw;
  logic [15:0] opb_abus;
  logic [31:0] opb_dbus;
  logic [31:0] sl_dbus;
  logic        sl_xferack;

  opb_spi_arbiter #(.TIMEOUT(TIMEOUT), .HOLDOFF(HOLDOFF)) dut (
    .opb_clk   (clk),
    .reset_n   (rst_n),
    .req       (req),
    .req_rnw   (req_rnw),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .gnt       (gnt),
    .done      (done),
    .err       (err),
    .rdata     (rdata),
    .busy      (busy),
    .opb_select(opb_select),
    .opb_rnw   (opb_rnw),
    .opb_abus  (opb_abus),
    .opb_dbus  (opb_dbus),
    .sl_dbus   (sl_dbus),
    .sl_xferack(sl_xferack)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          cyc;
    logic [1:0]  gnt;
    logic [15:0] abus;
    logic [31:0] dbus;
    logic        rnw;
  } start_t;

  typedef struct {
    int          cyc;
    logic [1:0]  done;
    logic [1:0]  err;
    logic [31:0] rdata;
  } end_t;

  start_t q_start[$];
  end_t   q_end[$];

  int          cyc;
  int          ack_delay = 0;  // cycles after select rises before ack; -1 = never ack
  int          ack_hold  = 1;  // cycles ack stays high
  logic [31:0] slv_data  = '0;
  int          n_cmp = 0;
  int          n_bad = 0;

  // Reference model state
  int          model_last  = 1;
  logic [31:0] model_rdata = '0;
  logic [15:0] a[2];
  logic [31:0] w[2];
  logic [1:0]  rw;

  function automatic int pick(input logic [1:0] r);
    if (r == 2'b01) return 0;
    if (r == 2'b10) return 1;
    return (model_last == 1) ? 0 : 1;
  endfunction

  function automatic logic [1:0] onehot(input int g);
    return (g == 1) ? 2'b10 : 2'b01;
  endfunction

  // Monitor and slave: sample 1 time unit after each rising edge.
  initial begin : monitor
    bit     sel_prev;
    int     sel_age;
    int     ack_left;
    start_t s;
    end_t   e;
    cyc = 0; sel_prev = 0; sel_age = 0; ack_left = 0;
    sl_xferack = 1'b0;
    sl_dbus = '0;
    forever begin
      @(posedge clk);
      #1;
      cyc++;
      if (opb_select && !sel_prev) begin
        s.cyc = cyc; s.gnt = gnt; s.abus = opb_abus; s.dbus = opb_dbus; s.rnw = opb_rnw;
        q_start.push_back(s);
        sel_age = 0;
      end else if (opb_select) begin
        sel_age++;
      end
      if (done != 2'b00) begin
        e.cyc = cyc; e.done = done; e.err = err; e.rdata = rdata;
        q_end.push_back(e);
      end
      if (ack_left > 0) begin
        ack_left--;
        if (ack_left == 0) sl_xferack = 1'b0;
      end else if (opb_select && ack_delay >= 0 && sel_age == ack_delay) begin
        sl_xferack = 1'b1;
        sl_dbus = slv_data;
        ack_left = ack_hold;
      end
      sel_prev = opb_select;
    end
  end

  initial begin : watchdog
    #300000;
    $display("FAIL watchdog: simulation time limit reached, got running want finished");
    $fatal(1);
  end

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic load();
    req_addr  = {a[1], a[0]};
    req_wdata = {w[1], w[0]};
    req_rnw   = rw;
  endtask

  // Raise req, wait (bounded) for the next start and completion records.
  task automatic run_one(input logic [1:0] r, input bit drop, output bit ok,
                         output start_t s, output end_t e);
    int n;
    ok = 1'b1;
    req = r;
    n = 0;
    while (q_start.size() == 0 && n < 60) begin step(); n++; end
    if (q_start.size() == 0) begin ok = 1'b0; return; end
    s = q_start.pop_front();
    n = 0;
    while (q_end.size() == 0 && n < 60) begin step(); n++; end
    if (q_end.size() == 0) begin ok = 1'b0; return; end
    e = q_end.pop_front();
    if (drop) req = 2'b00;
  endtask

  task automatic wait_idle(output bit ok);
    int n;
    n = 0;
    while (busy && n < 60) begin step(); n++; end
    ok = !busy;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    req = 2'b01;
    a[0] = 16'h1234; a[1] = 16'h5678; w[0] = 32'h1111_2222; w[1] = 32'h3333_4444; rw = 2'b11;
    load();
    #3;
    n_cmp++;
    if ({gnt, done, err, busy, opb_select, opb_rnw} !== 9'd0) begin
      n_bad++;
      $display("FAIL reset_ctrl: got %b want 0", {gnt, done, err, busy, opb_select, opb_rnw});
    end
    n_cmp++;
    if (rdata !== 32'd0) begin n_bad++; $display("FAIL reset_rdata: got %h want 0", rdata); end
    n_cmp++;
    if ({opb_abus, opb_dbus} !== 48'd0) begin
      n_bad++;
      $display("FAIL reset_bus: got %h want 0", {opb_abus, opb_dbus});
    end
    repeat (3) step();
    n_cmp++;
    if (busy !== 1'b0 || q_start.size() != 0) begin
      n_bad++;
      $display("FAIL reset_hold_grant: got busy=%b starts=%0d want 0/0", busy, q_start.size());
    end
    req = 2'b00;
    rst_n = 1'b1;
    repeat (2) step();
    n_cmp++;
    if (busy !== 1'b0) begin n_bad++; $display("FAIL reset_idle: got busy=%b want 0", busy); end
    model_last = 1;
    model_rdata = '0;
    q_start.delete();
    q_end.delete();
  endtask

  task automatic test_write_m0();
    bit ok; start_t s; end_t e; int t;
    ack_delay = 1; ack_hold = 1;
    a[0] = 16'h0010; w[0] = 32'hA5A5_0001; a[1] = 16'($urandom); w[1] = $urandom; rw = 2'b10;
    load();
    t = cyc;
    run_one(2'b01, 1'b1, ok, s, e);
    n_cmp++;
    if (!ok) begin n_bad++; $display("FAIL wr_complete: got timeout want start+done"); end
    n_cmp++;
    if (s.cyc !== t + 1) begin n_bad++; $display("FAIL wr_sel_lat: got %0d want %0d", s.cyc, t + 1); end
    n_cmp++;
    if ({s.gnt, s.abus, s.dbus, s.rnw} !== {2'b01, 16'h0010, 32'hA5A5_0001, 1'b0}) begin
      n_bad++;
      $display("FAIL wr_bus: got gnt=%b a=%h d=%h rnw=%b want 01/0010/a5a50001/0",
               s.gnt, s.abus, s.dbus, s.rnw);
    end
    n_cmp++;
    if ({e.done, e.err} !== 4'b0100) begin
      n_bad++; $display("FAIL wr_done: got done=%b err=%b want 01/00", e.done, e.err);
    end
    n_cmp++;
    if (e.cyc !== s.cyc + 2) begin
      n_bad++; $display("FAIL wr_done_lat: got %0d want %0d", e.cyc, s.cyc + 2);
    end
    model_last = 0;
    wait_idle(ok);
    n_cmp++;
    if (!ok || q_end.size() != 0) begin
      n_bad++; $display("FAIL wr_single_pulse: got idle=%b extra=%0d want 1/0", ok, q_end.size());
    end
  endtask

  task automatic test_read_m1();
    bit ok; start_t s; end_t e;
    ack_delay = int'($urandom_range(0, 4)); ack_hold = 1; slv_data = 32'hDEAD_BEEF;
    a[1] = 16'h0004; a[0] = 16'($urandom); w[0] = $urandom; w[1] = $urandom; rw = 2'b10;
    load();
    run_one(2'b10, 1'b1, ok, s, e);
    n_cmp++;
    if (!ok) begin n_bad++; $display("FAIL rd_complete: got timeout want start+done"); end
    n_cmp++;
    if ({s.gnt, s.abus, s.rnw} !== {2'b10, 16'h0004, 1'b1}) begin
      n_bad++; $display("FAIL rd_bus: got gnt=%b a=%h rnw=%b want 10/0004/1", s.gnt, s.abus, s.rnw);
    end
    n_cmp++;
    if ({e.done, e.err, e.rdata} !== {2'b10, 2'b00, 32'hDEAD_BEEF}) begin
      n_bad++;
      $display("FAIL rd_data: got done=%b err=%b rdata=%h want 10/00/deadbeef",
               e.done, e.err, e.rdata);
    end
    n_cmp++;
    if (e.cyc !== s.cyc + ack_delay + 1) begin
      n_bad++; $display("FAIL rd_lat: got %0d want %0d", e.cyc, s.cyc + ack_delay + 1);
    end
    model_last = 1;
    model_rdata = 32'hDEAD_BEEF;
    wait_idle(ok);
  endtask

  // Both requesters held: grants alternate; spacing = done + HOLDOFF + 1 with a 1-cycle ack.
  task automatic test_contention();
    bit ok; start_t s; end_t e; int g; int prev_done;
    ack_hold = 1;
    prev_done = 0;
    for (int i = 0; i < 4; i++) begin
      a[0] = 16'($urandom); a[1] = 16'($urandom); w[0] = $urandom; w[1] = $urandom;
      rw = 2'($urandom);
      load();
      ack_delay = int'($urandom_range(0, 4));
      slv_data = $urandom;
      g = pick(2'b11);
      run_one(2'b11, i == 3, ok, s, e);
      n_cmp++;
      if (!ok || s.gnt !== onehot(g)) begin
        n_bad++; $display("FAIL cont_gnt%0d: got %b want %b", i, s.gnt, onehot(g));
      end
      n_cmp++;
      if ({s.abus, s.dbus, s.rnw} !== {a[g], w[g], rw[g]}) begin
        n_bad++;
        $display("FAIL cont_bus%0d: got %h/%h/%b want %h/%h/%b", i, s.abus, s.dbus, s.rnw,
                 a[g], w[g], rw[g]);
      end
      if (i > 0) begin
        n_cmp++;
        if (s.cyc !== prev_done + HOLDOFF + 1) begin
          n_bad++;
          $display("FAIL cont_gap%0d: got start %0d want %0d", i, s.cyc, prev_done + HOLDOFF + 1);
        end
      end
      if (rw[g]) model_rdata = slv_data;
      n_cmp++;
      if ({e.done, e.err, e.rdata} !== {onehot(g), 2'b00, model_rdata}) begin
        n_bad++;
        $display("FAIL cont_done%0d: got %b/%b/%h want %b/00/%h", i, e.done, e.err, e.rdata,
                 onehot(g), model_rdata);
      end
      model_last = g;
      prev_done = e.cyc;
    end
    wait_idle(ok);
  endtask

  task automatic test_timeout();
    bit ok; start_t s; end_t e;
    ack_delay = -1;
    slv_data = ~model_rdata;
    a[0] = 16'($urandom); w[0] = $urandom; rw = 2'b01;
    load();
    run_one(2'b01, 1'b1, ok, s, e);
    n_cmp++;
    if (!ok || {e.done, e.err} !== 4'b0101) begin
      n_bad++; $display("FAIL to_flags: got done=%b err=%b want 01/01", e.done, e.err);
    end
    n_cmp++;
    if (e.cyc !== s.cyc + TIMEOUT) begin
      n_bad++; $display("FAIL to_lat: got %0d want %0d", e.cyc, s.cyc + TIMEOUT);
    end
    n_cmp++;
    if (e.rdata !== model_rdata) begin
      n_bad++; $display("FAIL to_rdata: got %h want %h", e.rdata, model_rdata);
    end
    n_cmp++;
    if (opb_select !== 1'b0) begin
      n_bad++; $display("FAIL to_sel_drop: got %b want 0", opb_select);
    end
    model_last = 0;
    ack_delay = 0;
    wait_idle(ok);
  endtask

  // Ack held 6 cycles past the acknowledging one: next grant waits for ack to drop.
  task automatic test_sticky();
    bit ok; start_t s; end_t e; int d1; int hold_edges;
    ack_delay = 2; ack_hold = 7;
    a[0] = 16'($urandom); a[1] = 16'($urandom); w[0] = $urandom; w[1] = $urandom; rw = 2'b00;
    load();
    run_one(2'b11, 1'b0, ok, s, e);
    n_cmp++;
    if (!ok || s.gnt !== onehot(pick(2'b11))) begin
      n_bad++; $display("FAIL sticky_gnt0: got %b want %b", s.gnt, onehot(pick(2'b11)));
    end
    model_last = pick(2'b11);
    d1 = e.cyc;
    ack_hold = 1;
    run_one(2'b11, 1'b1, ok, s, e);
    hold_edges = (HOLDOFF > 7) ? HOLDOFF : 7;
    n_cmp++;
    if (!ok || s.cyc !== d1 + hold_edges + 1) begin
      n_bad++; $display("FAIL sticky_gap: got start %0d want %0d", s.cyc, d1 + hold_edges + 1);
    end
    n_cmp++;
    if (s.gnt !== onehot(pick(2'b11))) begin
      n_bad++; $display("FAIL sticky_gnt1: got %b want %b", s.gnt, onehot(pick(2'b11)));
    end
    model_last = pick(2'b11);
    wait_idle(ok);
  endtask

  task automatic test_reset_mid();
    bit ok; start_t s; end_t e; int n;
    ack_delay = -1;
    a[1] = 16'($urandom); w[1] = $urandom; rw = 2'b00;
    load();
    req = 2'b10;
    n = 0;
    while (q_start.size() == 0 && n < 20) begin step(); n++; end
    n_cmp++;
    if (q_start.size() == 0) begin
      n_bad++; $display("FAIL rmid_start: got no select want select");
    end else begin
      s = q_start.pop_front();
    end
    repeat (3) step();
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if ({opb_select, gnt, busy, done} !== 6'd0) begin
      n_bad++;
      $display("FAIL rmid_async: got sel=%b gnt=%b busy=%b done=%b want 0", opb_select, gnt,
               busy, done);
    end
    req = 2'b00;
    repeat (2) step();
    rst_n = 1'b1;
    model_last = 1;
    model_rdata = '0;
    repeat (2) step();
    n_cmp++;
    if (q_end.size() != 0 || rdata !== 32'd0) begin
      n_bad++; $display("FAIL rmid_nodone: got dones=%0d rdata=%h want 0/0", q_end.size(), rdata);
    end
    ack_delay = 0;
    run_one(2'b11, 1'b1, ok, s, e);
    n_cmp++;
    if (!ok || s.gnt !== 2'b01) begin
      n_bad++; $display("FAIL rmid_first_m0: got %b want 01", s.gnt);
    end
    model_last = 0;
    wait_idle(ok);
  endtask

  task automatic test_random();
    bit ok; start_t s; end_t e; int g; logic [1:0] r; bit to; int lat;
    for (int i = 0; i < 24; i++) begin
      r = 2'($urandom_range(1, 3));
      a[0] = 16'($urandom); a[1] = 16'($urandom); w[0] = $urandom; w[1] = $urandom;
      rw = 2'($urandom);
      load();
      to = ($urandom_range(0, 5) == 0);
      ack_delay = to ? -1 : int'($urandom_range(0, 5));
      ack_hold = int'($urandom_range(1, 4));
      slv_data = $urandom;
      g = pick(r);
      run_one(r, 1'b1, ok, s, e);
      if (!to && rw[g]) model_rdata = slv_data;
      lat = to ? TIMEOUT : ack_delay + 1;
      n_cmp++;
      if (!ok || {s.gnt, s.abus, s.dbus, s.rnw} !== {onehot(g), a[g], w[g], rw[g]}) begin
        n_bad++;
        $display("FAIL rnd_start%0d: got %b/%h/%h/%b want %b/%h/%h/%b", i, s.gnt, s.abus,
                 s.dbus, s.rnw, onehot(g), a[g], w[g], rw[g]);
      end
      n_cmp++;
      if ({e.done, e.err, e.rdata} !== {onehot(g), to ? onehot(g) : 2'b00, model_rdata}) begin
        n_bad++;
        $display("FAIL rnd_end%0d: got %b/%b/%h want %b/%b/%h", i, e.done, e.err, e.rdata,
                 onehot(g), to ? onehot(g) : 2'b00, model_rdata);
      end
      n_cmp++;
      if (e.cyc !== s.cyc + lat) begin
        n_bad++; $display("FAIL rnd_lat%0d: got %0d want %0d", i, e.cyc - s.cyc, lat);
      end
      model_last = g;
      wait_idle(ok);
      n_cmp++;
      if (!ok || q_end.size() != 0) begin
        n_bad++; $display("FAIL rnd_idle%0d: got idle=%b extra=%0d want 1/0", i, ok, q_end.size());
      end
    end
  endtask

  initial begin
    req = 2'b00;
    req_rnw = 2'b00;
    req_addr = '0;
    req_wdata = '0;
    test_reset();
    test_write_m0();
    test_read_m1();
    test_contention();
    test_timeout();
    test_sticky();
    test_reset_mid();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
